// File: rtl/fetch_unit_pkg.sv
// Shared widths, queue entry layout and PC reset value for the fetch unit.
package fetch_unit_pkg;

  localparam int N_DEFAULT      = 32;
  localparam int NINSTR_DEFAULT = 7;

  localparam logic [NINSTR_DEFAULT-1:0] PC_RESET = '0;

  typedef struct packed {
    logic [N_DEFAULT-1:0]      instr;
    logic [NINSTR_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch unit.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int n      = N_DEFAULT,
  parameter int nInstr = NINSTR_DEFAULT
);
  logic              imem_req;
  logic [nInstr-1:0] imem_addr;
  logic [n-1:0]      imem_rdata;
  logic              redirect;
  logic [nInstr-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [n-1:0]      out_instr;
  logic [nInstr-1:0] out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, redirect, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small circular queue of fetched {instr, pc} entries with a synchronous flush.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  entry_t        wdata_i,
  output entry_t        head_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Guards keep the queue consistent even if a caller pushes full or pops empty.
  assign do_push = push_i && ((count_q != FULL) || pop_i);
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC sequencing, instruction-memory requests and redirect handling
// in front of fetch_queue, which buffers returned instructions for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int n      = N_DEFAULT,
  parameter int nInstr = NINSTR_DEFAULT,
  parameter int DEPTH  = 2
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);
  typedef struct packed {
    logic [n-1:0]      instr;
    logic [nInstr-1:0] pc;
  } entry_t;

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]        OCC_FULL = (CW + 1)'(DEPTH);
  localparam logic [nInstr-1:0]  PC_INIT  = nInstr'(PC_RESET);

  logic [nInstr-1:0] pc_q, pc_d;
  logic              fl_q, fl_d;
  logic [nInstr-1:0] fl_pc_q, fl_pc_d;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic              req, deq, enq, valid;
  entry_t            head, tail;

  assign occ   = {1'b0, count} + (CW + 1)'(fl_q);
  assign valid = (count != '0) && !bus.redirect;
  assign deq   = valid && bus.out_ready;
  // A slot freed by this cycle's dequeue may be refilled by this cycle's
  // request; that is what sustains one instruction per cycle.
  assign req   = !reset && !bus.redirect &&
                 ((occ < OCC_FULL) || ((occ == OCC_FULL) && deq));
  assign enq   = fl_q && !bus.redirect;
  assign tail  = {bus.imem_rdata, fl_pc_q};

  always_comb begin
    pc_d    = pc_q;
    fl_d    = req;
    fl_pc_d = fl_pc_q;
    if (bus.redirect) begin
      pc_d = bus.redirect_pc;
    end else if (req) begin
      pc_d    = pc_q + nInstr'(1);
      fl_pc_d = pc_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= PC_INIT;
      fl_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      fl_q <= fl_d;
    end
  end

  always_ff @(posedge clock) begin
    fl_pc_q <= fl_pc_d;
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .flush_i (bus.redirect),
    .push_i  (enq),
    .pop_i   (deq),
    .wdata_i (tail),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? head.instr : '0;
  assign bus.out_pc    = valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// stream-level reference model (in-order PCs from each restart point).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int N     = 32;
  localparam int NI    = 7;
  localparam int DEPTH = 2;

  logic        clock;
  logic        reset;
  logic [31:0] salt;
  int          n_cmp;
  int          n_fail;

  fetch_unit_if #(.n(N), .nInstr(NI)) bus ();

  fetch_unit #(.n(N), .nInstr(NI), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [N-1:0] word_of(input logic [NI-1:0] a);
    return 32'h100 + 32'(a) + salt;
  endfunction

  // Instruction memory: data one cycle after the request, garbage otherwise.
  always @(posedge clock)
    bus.imem_rdata <= bus.imem_req ? word_of(bus.imem_addr) : 32'hDEADBEEF;

  task automatic step_in(input logic rdy, input logic redir, input logic [NI-1:0] rpc);
    @(posedge clock);
    #1;
    bus.out_ready   = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    #1;
  endtask

  task automatic restart(input logic rdy);
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.out_ready = rdy;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [39:0] got, exp;
    logic [7:0]  gr, er;
    reset = 1'b1;
    step_in(1'b1, 1'b0, '0);
    step_in(1'b1, 1'b0, '0);
    got = {bus.out_valid, bus.out_pc, bus.out_instr};
    n_cmp++;
    if (got !== 40'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", got, 40'd0); end
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    gr = {bus.imem_req, bus.imem_addr}; er = {1'b1, 7'd0};
    n_cmp++;
    if (gr !== er) begin n_fail++; $display("FAIL first_req: got %h want %h", gr, er); end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid_early: got %b want 0", bus.out_valid); end
    step_in(1'b1, 1'b0, '0);
    gr = {bus.imem_req, bus.imem_addr}; er = {1'b1, 7'd1};
    n_cmp++;
    if (gr !== er) begin n_fail++; $display("FAIL second_req: got %h want %h", gr, er); end
    step_in(1'b1, 1'b0, '0);
    got = {bus.out_valid, bus.out_pc, bus.out_instr}; exp = {1'b1, 7'd0, 32'h100};
    n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL first_out: got %h want %h", got, exp); end
  endtask

  task automatic test_stream();
    logic [39:0] got, exp;
    salt = 0;
    restart(1'b1);
    for (int c = 1; c <= 5; c++) begin
      step_in(1'b1, 1'b0, '0);
      if (c >= 2) begin
        got = {bus.out_valid, bus.out_pc, bus.out_instr};
        exp = {1'b1, 7'(c - 2), 32'h100 + 32'(c - 2)};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL stream_c%0d: got %h want %h", c, got, exp); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] got, exp;
    salt = 0;
    restart(1'b0);
    for (int c = 1; c <= 4; c++) begin
      step_in(1'b0, 1'b0, '0);
      n_cmp++;
      if (bus.imem_req !== (c == 1)) begin
        n_fail++; $display("FAIL bp_req_c%0d: got %b want %b", c, bus.imem_req, (c == 1));
      end
      if (c >= 2) begin
        got = {bus.out_valid, bus.out_pc, bus.out_instr}; exp = {1'b1, 7'd0, 32'h100};
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL bp_hold_c%0d: got %h want %h", c, got, exp); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      step_in(1'b1, 1'b0, '0);
      got = {bus.out_valid, bus.out_pc, bus.out_instr}; exp = {1'b1, 7'(k), 32'h100 + 32'(k)};
      n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL bp_drain_%0d: got %h want %h", k, got, exp); end
    end
  endtask

  task automatic redirect_case(input int settle, input logic [NI-1:0] tgt);
    logic [39:0] got, exp;
    logic [7:0]  gr, er;
    restart(1'b0);
    for (int c = 1; c < settle; c++) step_in(1'b0, 1'b0, '0);
    step_in(1'b0, 1'b1, tgt);
    gr = {bus.out_valid, bus.imem_req};
    n_cmp++;
    if (gr !== 8'd0) begin n_fail++; $display("FAIL redir_cycle_%h: got %h want 00", tgt, gr); end
    step_in(1'b0, 1'b0, '0);
    gr = {bus.imem_req, bus.imem_addr}; er = {1'b1, tgt};
    n_cmp++;
    if (gr !== er) begin n_fail++; $display("FAIL redir_req_%h: got %h want %h", tgt, gr, er); end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale_%h: got %b want 0", tgt, bus.out_valid); end
    step_in(1'b0, 1'b0, '0);
    step_in(1'b1, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      got = {bus.out_valid, bus.out_pc, bus.out_instr};
      exp = {1'b1, tgt + 7'(k), word_of(tgt + 7'(k))};
      n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL redir_out_%h_%0d: got %h want %h", tgt, k, got, exp); end
      step_in(1'b1, 1'b0, '0);
    end
  endtask

  task automatic test_redirect();
    salt = 0;
    redirect_case(3, 7'h40);
    redirect_case(4, 7'h10);
  endtask

  task automatic test_wrap();
    logic [39:0] got, exp;
    logic [7:0]  gr, er;
    salt = 0;
    restart(1'b1);
    step_in(1'b1, 1'b1, 7'h7F);
    step_in(1'b1, 1'b0, '0);
    gr = {bus.imem_req, bus.imem_addr}; er = {1'b1, 7'h7F};
    n_cmp++;
    if (gr !== er) begin n_fail++; $display("FAIL wrap_req_7f: got %h want %h", gr, er); end
    step_in(1'b1, 1'b0, '0);
    gr = {bus.imem_req, bus.imem_addr}; er = {1'b1, 7'h00};
    n_cmp++;
    if (gr !== er) begin n_fail++; $display("FAIL wrap_req_00: got %h want %h", gr, er); end
    for (int k = 0; k < 3; k++) begin
      step_in(1'b1, 1'b0, '0);
      got = {bus.out_valid, bus.out_pc, bus.out_instr};
      exp = {1'b1, 7'h7F + 7'(k), word_of(7'h7F + 7'(k))};
      n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL wrap_out_%0d: got %h want %h", k, got, exp); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [39:0] got, exp;
    logic [7:0]  gr, er;
    salt = 0;
    restart(1'b0);
    for (int c = 1; c <= 3; c++) step_in(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid); end
    reset = 1'b1;
    #1;
    got = {bus.out_valid, bus.out_pc, bus.out_instr};
    n_cmp++;
    if (got !== 40'd0) begin n_fail++; $display("FAIL mid_reset_out: got %h want %h", got, 40'd0); end
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_reset_req: got %b want 0", bus.imem_req); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    gr = {bus.imem_req, bus.imem_addr}; er = {1'b1, 7'd0};
    n_cmp++;
    if (gr !== er) begin n_fail++; $display("FAIL mid_restart_req: got %h want %h", gr, er); end
    step_in(1'b1, 1'b0, '0);
    step_in(1'b1, 1'b0, '0);
    got = {bus.out_valid, bus.out_pc, bus.out_instr}; exp = {1'b1, 7'd0, 32'h100};
    n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL mid_restart_out: got %h want %h", got, exp); end
  endtask

  task automatic test_random();
    logic [NI-1:0] exp_req, exp_dlv, held_pc, rpc;
    logic [N-1:0]  held_instr;
    logic [39:0]   got, exp;
    logic          stalled, rdy, redir;
    int            outstanding, delivered;
    salt = $urandom & 32'h0FFF_F000;
    restart(1'b1);
    exp_req = '0; exp_dlv = '0; outstanding = 0; delivered = 0; stalled = 1'b0;
    held_pc = '0; held_instr = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 0) begin
        rdy = 1'b1; redir = 1'b0; rpc = '0;
      end else begin
        rdy   = ($urandom_range(0, 9) < 7);
        redir = ($urandom_range(0, 39) == 0);
        rpc   = 7'($urandom);
        step_in(rdy, redir, rpc);
      end
      if (redir) begin
        n_cmp++;
        if ({bus.out_valid, bus.imem_req} !== 2'b00) begin
          n_fail++; $display("FAIL rnd_redir_%0d: got %b%b want 00", i, bus.out_valid, bus.imem_req);
        end
        exp_req = rpc; exp_dlv = rpc; outstanding = 0; stalled = 1'b0;
      end else begin
        if (stalled) begin
          got = {bus.out_valid, bus.out_pc, bus.out_instr}; exp = {1'b1, held_pc, held_instr};
          n_cmp++;
          if (got !== exp) begin n_fail++; $display("FAIL rnd_stable_%0d: got %h want %h", i, got, exp); end
        end
        if (bus.imem_req) begin
          n_cmp++;
          if (bus.imem_addr !== exp_req) begin
            n_fail++; $display("FAIL rnd_addr_%0d: got %h want %h", i, bus.imem_addr, exp_req);
          end
          exp_req = exp_req + 7'd1;
          outstanding++;
        end
        if (bus.out_valid) begin
          got = {1'b1, bus.out_pc, bus.out_instr}; exp = {1'b1, exp_dlv, word_of(exp_dlv)};
          n_cmp++;
          if (got !== exp) begin n_fail++; $display("FAIL rnd_out_%0d: got %h want %h", i, got, exp); end
          if (rdy) begin
            exp_dlv = exp_dlv + 7'd1;
            outstanding--;
            delivered++;
          end
        end
        n_cmp++;
        if (outstanding > DEPTH || outstanding < 0) begin
          n_fail++; $display("FAIL rnd_occupancy_%0d: got %0d want 0..%0d", i, outstanding, DEPTH);
        end
        stalled    = bus.out_valid && !rdy;
        held_pc    = bus.out_pc;
        held_instr = bus.out_instr;
      end
    end
    n_cmp++;
    if (delivered < 800) begin n_fail++; $display("FAIL rnd_delivered: got %0d want >= 800", delivered); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    salt = 0;
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
